montgomery_mult: RTL

- Bit-serial radix-2 Montgomery multiplier. Computes P = A·B·R⁻¹ mod M, where R = 2^WIDTH.
- Sits directly downstream of the Montgomery constant generator, which supplies R mod M and R² mod M.
- Typical use: A = message or running product, B = R² mod M, to convert into the Montgomery domain. Later calls perform modular multiplications for the RSA decryption exponentiation loop.
- One multi-cycle operation at a time, controlled by a start/done handshake.

---
 rtl/rsa_pkg.sv | 12 +
 rtl/mont_iter.sv | 24 ++
 rtl/montgomery_mult.sv | 104 ++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared RSA datapath definitions: operand width and the common control-state encoding.
package rsa_pkg;

  localparam int unsigned RSA_WIDTH = 1024;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    SUB
  } state_t;

endpackage

// File: rtl/mont_iter.sv
// One radix-2 Montgomery step: S_next = (S + a_bit*B + q*M) / 2, with q chosen so the sum is even.
module mont_iter
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = RSA_WIDTH
) (
  input  logic [WIDTH+1:0] s,
  input  logic             a_bit,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH+1:0] s_next
);

  logic             q;
  logic [WIDTH+1:0] sum;

  // S < 2M and B, M < 2^WIDTH keep the sum below 2^(WIDTH+2).
  always_comb begin
    q      = s[0] ^ (a_bit & b[0]);
    sum    = s + (a_bit ? {2'b00, b} : '0) + (q ? {2'b00, m} : '0);
    s_next = {1'b0, sum[WIDTH+1:1]};
  end

endmodule

// File: rtl/montgomery_mult.sv
// Bit-serial radix-2 Montgomery multiplier: P = A*B*2^-WIDTH mod M, WIDTH+1 cycles per operation.
module montgomery_mult
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = RSA_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] M,
  output logic [WIDTH-1:0] P,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH+1:0] s_q, s_d, s_step;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, m_q, m_d;
  logic [WIDTH-1:0] p_d;
  logic             busy_d, done_d;

  mont_iter #(.WIDTH(WIDTH)) u_iter (
    .s      (s_q),
    .a_bit  (a_q[0]),
    .b      (b_q),
    .m      (m_q),
    .s_next (s_step)
  );

  // A is held as a shift register so the current multiplier bit is always a_q[0].
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    p_d     = P;
    busy_d  = busy;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          m_d     = M;
          s_d     = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ITER;
        end
      end
      ITER: begin
        s_d   = s_step;
        a_d   = a_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = SUB;
        end
      end
      SUB: begin
        // Compare on WIDTH+1 bits; the difference is only needed modulo 2^WIDTH.
        if (s_q[WIDTH:0] >= {1'b0, m_q}) begin
          p_d = s_q[WIDTH-1:0] - m_q;
        end else begin
          p_d = s_q[WIDTH-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      P       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      P       <= p_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule
